fp_round_pipe: RTL and testbench

Parametrised, pipelined rounding and packing stage for the floating-point multiplier datapath. It takes a normalised product mantissa with round/sticky bits and an unbounded signed exponent, and applies one of four IEEE-754 rounding modes selected per transaction. It handles post-rounding renormalisation, overflow/underflow saturation and special operands, then packs the sign/exponent/fraction word. It sits between the multiplier's normalisation stage and the result bus, with valid/ready handshakes on both sides.

---
 rtl/fp_round_pipe.sv | 166 ++++++++++++++++
 tb/tb_fp_round_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// Two-stage rounding/packing stage for the FP multiplier: stage 1 decides the
// increment and adds it, stage 2 renormalises, range-checks and packs the result.
module fp_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [MAN_W:0]         in_mant,
  input  logic                   in_rnd,
  input  logic                   in_stk,
  input  logic [1:0]             in_mode,
  input  logic [1:0]             in_special,
  input  logic                   in_invalid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [4:0]             out_flags
);

  localparam int ZW = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W+2:0] EXP_OVF = {3'b000, EXP_ONES};

  localparam logic [1:0] MODE_RNE = 2'b00;
  localparam logic [1:0] MODE_RTZ = 2'b01;
  localparam logic [1:0] MODE_RUP = 2'b10;
  localparam logic [1:0] MODE_RDN = 2'b11;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_INF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

  logic s1Valid, s2Valid;
  logic s1Adv, s2Adv;

  logic             s1Sign;
  logic [EXP_W+1:0] s1Exp;
  logic [MAN_W+1:0] s1Sum;
  logic             s1Inexact;
  logic [1:0]       s1Mode;
  logic [1:0]       s1Special;
  logic             s1Invalid;

  assign s2Adv    = ~s2Valid | out_ready;
  assign s1Adv    = ~s1Valid | s2Adv;
  assign in_ready = s1Adv;
  assign out_valid = s2Valid;

  logic             incr;
  logic [MAN_W+1:0] inSum;

  always_comb begin
    incr = 1'b0;
    case (in_mode)
      MODE_RNE: incr = in_rnd & (in_stk | in_mant[0]);
      MODE_RTZ: incr = 1'b0;
      MODE_RUP: incr = (in_rnd | in_stk) & ~in_sign;
      MODE_RDN: incr = (in_rnd | in_stk) & in_sign;
      default:  incr = 1'b0;
    endcase
  end

  assign inSum = {1'b0, in_mant} + {{(MAN_W+1){1'b0}}, incr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1Sign    <= 1'b0;
      s1Exp     <= '0;
      s1Sum     <= '0;
      s1Inexact <= 1'b0;
      s1Mode    <= '0;
      s1Special <= '0;
      s1Invalid <= 1'b0;
    end else if (s1Adv) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Sign    <= in_sign;
        s1Exp     <= in_exp;
        s1Sum     <= inSum;
        s1Inexact <= in_rnd | in_stk;
        s1Mode    <= in_mode;
        s1Special <= in_special;
        s1Invalid <= in_invalid;
      end
    end
  end

  // Exponent carries one extra bit so the renormalising +1 can never wrap.
  logic             carry;
  logic [MAN_W:0]   normMant;
  logic [EXP_W+2:0] normExp;
  logic             isOvf, isUnf, toInf;
  logic [ZW-1:0]    packZ;
  logic [4:0]       packFlags;

  assign carry    = s1Sum[MAN_W+1];
  assign normMant = carry ? s1Sum[MAN_W+1:1] : s1Sum[MAN_W:0];
  assign normExp  = {s1Exp[EXP_W+1], s1Exp} + {{(EXP_W+2){1'b0}}, carry};
  assign isUnf    = normExp[EXP_W+2] | (normExp == '0);
  assign isOvf    = ~normExp[EXP_W+2] & (normExp >= EXP_OVF);

  always_comb begin
    toInf = 1'b0;
    case (s1Mode)
      MODE_RNE: toInf = 1'b1;
      MODE_RTZ: toInf = 1'b0;
      MODE_RUP: toInf = ~s1Sign;
      MODE_RDN: toInf = s1Sign;
      default:  toInf = 1'b0;
    endcase
  end

  // flags = {invalid, overflow, underflow, inexact, zero}
  always_comb begin
    packZ        = '0;
    packFlags    = '0;
    packFlags[4] = s1Invalid;
    case (s1Special)
      SP_ZERO: begin
        packZ        = {s1Sign, {(ZW-1){1'b0}}};
        packFlags[0] = 1'b1;
      end
      SP_INF:  packZ = {s1Sign, EXP_ONES, {MAN_W{1'b0}}};
      SP_NAN:  packZ = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      default: begin
        if (isOvf) begin
          packZ        = toInf ? {s1Sign, EXP_ONES, {MAN_W{1'b0}}}
                               : {s1Sign, EXP_MAXF, {MAN_W{1'b1}}};
          packFlags[3] = 1'b1;
          packFlags[1] = 1'b1;
        end else if (isUnf) begin
          packZ        = {s1Sign, {(ZW-1){1'b0}}};
          packFlags[2] = 1'b1;
          packFlags[1] = 1'b1;
          packFlags[0] = 1'b1;
        end else begin
          packZ        = {s1Sign, normExp[EXP_W-1:0], normMant[MAN_W-1:0]};
          packFlags[1] = s1Inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid   <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else if (s2Adv) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        out_z     <= packZ;
        out_flags <= packFlags;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed vectors with literal expectations plus a
// behavioural reference model and an in-order scoreboard on the output side.
module tb_fp_round_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_rnd, in_stk, in_invalid;
  logic [9:0]  in_exp;
  logic [23:0] in_mant;
  logic [1:0]  in_mode, in_special;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic [4:0]  out_flags;

  fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_rnd(in_rnd), .in_stk(in_stk), .in_mode(in_mode),
    .in_special(in_special), .in_invalid(in_invalid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        rnd, stk;
    logic [1:0]  mode, special;
    logic        invalid;
    logic        hasLit;
    logic [31:0] litZ;
    logic [4:0]  litF;
  } vec_t;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  f;
    logic        hasLit;
    logic [31:0] litZ;
    logic [4:0]  litF;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  exp_t scb[$];
  vec_t cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the rounding rules.
  function automatic logic [36:0] model(input logic sign, input int e, input int m,
      input logic rnd, input logic stk, input logic [1:0] mode,
      input logic [1:0] special, input logic invalid);
    logic [31:0] z;
    logic [4:0]  f;
    int up;
    bit toInf;
    f = 5'b0;
    f[4] = invalid;
    if (special == 2'd1) begin
      z = sign ? 32'h8000_0000 : 32'h0; f[0] = 1'b1;
    end else if (special == 2'd2) begin
      z = sign ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if (special == 2'd3) begin
      z = 32'h7FC0_0000;
    end else begin
      case (mode)
        2'd0: up = (rnd && (stk || (m % 2 == 1))) ? 1 : 0;
        2'd1: up = 0;
        2'd2: up = ((rnd || stk) && !sign) ? 1 : 0;
        default: up = ((rnd || stk) && sign) ? 1 : 0;
      endcase
      m = m + up;
      if (m >= (1 << 24)) begin m = m / 2; e = e + 1; end
      if (e >= 255) begin
        toInf = (mode == 2'd0) || (mode == 2'd2 && !sign) || (mode == 2'd3 && sign);
        z = toInf ? {sign, 31'h7F80_0000} : {sign, 31'h7F7F_FFFF};
        f[3] = 1'b1; f[1] = 1'b1;
      end else if (e <= 0) begin
        z = {sign, 31'h0}; f[2] = 1'b1; f[1] = 1'b1; f[0] = 1'b1;
      end else begin
        z = {sign, 31'(e * (1 << 23) + (m - (1 << 23)))};
        f[1] = rnd | stk;
      end
    end
    return {z, f};
  endfunction

  // Compare process: output checked against scoreboard head on every valid cycle.
  always @(negedge clk) begin
    logic [36:0] mr;
    exp_t e;
    if (!rst_n) begin
      scb.delete();
    end else begin
      if (out_valid) begin
        if (scb.size() == 0) begin
          chk("spurious_out", {63'b0, out_valid}, 64'd0);
        end else begin
          chk("z_model", {32'b0, out_z}, {32'b0, scb[0].z});
          chk("flags_model", {59'b0, out_flags}, {59'b0, scb[0].f});
          if (scb[0].hasLit) begin
            chk("z_literal", {32'b0, out_z}, {32'b0, scb[0].litZ});
            chk("flags_literal", {59'b0, out_flags}, {59'b0, scb[0].litF});
          end
          if (out_ready) void'(scb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        mr = model(in_sign, int'($signed(in_exp)), int'(in_mant), in_rnd, in_stk,
                   in_mode, in_special, in_invalid);
        e.z = mr[36:5]; e.f = mr[4:0];
        e.hasLit = cur.hasLit; e.litZ = cur.litZ; e.litF = cur.litF;
        scb.push_back(e);
      end
    end
  end

  task automatic send(input vec_t v);
    bit acc;
    int n;
    cur = v;
    in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
    in_rnd = v.rnd; in_stk = v.stk; in_mode = v.mode;
    in_special = v.special; in_invalid = v.invalid;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode = 2'b11; in_special = 2'b11;
  endtask

  task automatic drain();
    int n = 0;
    while ((scb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", {63'b0, (n >= 200)}, 64'd0);
  endtask

  function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [23:0] m,
      input logic r, input logic k, input logic [1:0] md, input logic [1:0] sp,
      input logic inv, input logic [31:0] lz, input logic [4:0] lf);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.rnd = r; v.stk = k; v.mode = md;
    v.special = sp; v.invalid = inv; v.hasLit = 1'b1; v.litZ = lz; v.litF = lf;
    return v;
  endfunction

  vec_t dirVecs[$];

  initial begin
    vec_t v;
    cur = '0;
    rst_n = 1'b0; out_ready = 1'b1;
    idle();
    in_sign = 0; in_exp = 0; in_mant = 0; in_rnd = 0; in_stk = 0; in_invalid = 0;
    #12;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_z", {32'b0, out_z}, 64'd0);
    chk("rst_out_flags", {59'b0, out_flags}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // sign exp mant rnd stk mode special invalid | expected z, flags
    dirVecs.push_back(mk(0, 10'd127, 24'h800001, 1, 0, 2'd0, 2'd0, 0, 32'h3F800002, 5'b00010));
    dirVecs.push_back(mk(0, 10'd127, 24'h800000, 1, 0, 2'd0, 2'd0, 0, 32'h3F800000, 5'b00010));
    dirVecs.push_back(mk(0, 10'd127, 24'h800001, 1, 0, 2'd1, 2'd0, 0, 32'h3F800001, 5'b00010));
    dirVecs.push_back(mk(0, 10'd127, 24'h800000, 1, 0, 2'd1, 2'd0, 0, 32'h3F800000, 5'b00010));
    dirVecs.push_back(mk(0, 10'd127, 24'hFFFFFF, 1, 0, 2'd0, 2'd0, 0, 32'h40000000, 5'b00010));
    dirVecs.push_back(mk(1, 10'd127, 24'hFFFFFF, 1, 0, 2'd3, 2'd0, 0, 32'hC0000000, 5'b00010));
    dirVecs.push_back(mk(0, 10'd127, 24'hFFFFFF, 1, 0, 2'd3, 2'd0, 0, 32'h3FFFFFFF, 5'b00010));
    dirVecs.push_back(mk(0, 10'd254, 24'hFFFFFF, 1, 0, 2'd0, 2'd0, 0, 32'h7F800000, 5'b01010));
    dirVecs.push_back(mk(0, 10'd254, 24'hFFFFFF, 1, 0, 2'd1, 2'd0, 0, 32'h7F7FFFFF, 5'b00010));
    dirVecs.push_back(mk(1, 10'd254, 24'hFFFFFF, 1, 0, 2'd2, 2'd0, 0, 32'hFF7FFFFF, 5'b00010));
    dirVecs.push_back(mk(0, 10'd254, 24'hFFFFFF, 1, 0, 2'd2, 2'd0, 0, 32'h7F800000, 5'b01010));
    dirVecs.push_back(mk(0, 10'd300, 24'h800000, 0, 0, 2'd3, 2'd0, 0, 32'h7F7FFFFF, 5'b01010));
    dirVecs.push_back(mk(1, 10'd0,   24'h800000, 0, 0, 2'd0, 2'd0, 0, 32'h80000000, 5'b00111));
    dirVecs.push_back(mk(1, 10'h3FB, 24'h800000, 0, 0, 2'd0, 2'd0, 0, 32'h80000000, 5'b00111));
    dirVecs.push_back(mk(0, 10'd5,   24'h800000, 0, 0, 2'd0, 2'd3, 1, 32'h7FC00000, 5'b10000));
    dirVecs.push_back(mk(1, 10'd5,   24'h800000, 0, 0, 2'd0, 2'd2, 0, 32'hFF800000, 5'b00000));
    dirVecs.push_back(mk(0, 10'd5,   24'h800000, 0, 0, 2'd0, 2'd1, 0, 32'h00000000, 5'b00001));

    foreach (dirVecs[i]) send(dirVecs[i]);
    idle();
    drain();

    // Backpressure: 4 back-to-back with the output stalled for 6 cycles.
    accepts = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(dirVecs[i + 4]);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_accepts", 64'(accepts), 64'd2);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", 64'(accepts), 64'd4);

    // Random normal/special traffic with random output backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int r;
          v = '0;
          v.sign = 1'($urandom_range(0, 1));
          v.exp = 10'($signed($urandom_range(0, 259)) - 2);
          v.mant = {1'b1, 23'($urandom)};
          v.rnd = 1'($urandom_range(0, 1));
          v.stk = 1'($urandom_range(0, 1));
          v.mode = 2'($urandom_range(0, 3));
          r = $urandom_range(0, 7);
          v.special = (r < 5) ? 2'd0 : 2'(r - 4);
          v.invalid = 1'($urandom_range(0, 1));
          send(v);
        end
        idle();
      end
      begin
        repeat (80) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a stall: everything in flight is discarded.
    out_ready = 1'b0;
    send(dirVecs[0]);
    send(dirVecs[1]);
    idle();
    @(posedge clk); #3;
    chk("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_out_z", {32'b0, out_z}, 64'd0);
    chk("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
